// File: rtl/lcd_pkg.sv
// Shared definitions for the PCD8544 SPI transmit path.
// Holds the D/C line encodings, the {dc, byte} FIFO entry width and the
// transmitter FSM state encoding used by lcd_spi_tx.
package lcd_pkg;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  // One queued entry is {dc, byte}.
  localparam int LCD_ENTRY_W = 9;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/lcd_tx_fifo.sv
// Small synchronous FIFO of {dc, byte} entries feeding the SPI shifter.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   push, wr_entry  write an entry (ignored when full)
//   pop, rd_entry   read side; rd_entry shows the head entry, pop removes it
//   full, empty     status flags
//   count           number of stored entries (registered)
module lcd_tx_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [LCD_ENTRY_W-1:0] wr_entry,
  input  logic                   pop,
  output logic [LCD_ENTRY_W-1:0] rd_entry,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [LCD_ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   fresh;
  logic                   do_push;
  logic                   do_pop;

  // An entry written into an empty FIFO becomes readable one cycle later,
  // so the read side never depends combinationally on the write port.
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0) || fresh;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = mem[rd_ptr];

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fresh  <= 1'b0;
    end else begin
      fresh <= do_push && (count == '0);
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_spi_tx.sv
// Write-only SPI (mode 0) byte transmitter for the PCD8544 LCD.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   wr_data, wr_dc             byte and D/C flag offered by the sequencer
//   wr_valid, wr_ready         handshake; transfer on wr_valid & wr_ready
//   mosi, sclk, cs, dc         panel pins (sclk idles low, cs active-low)
//   busy                       queue non-empty or a frame in progress
//   byte_done                  one-cycle pulse after the last bit of a byte
// Bytes are sent MSB first; cs stays low across back-to-back bytes and is
// held high for CS_GAP cycles after each frame.
module lcd_spi_tx
  import lcd_pkg::*;
#(
  parameter int DIV_HALF   = 2,
  parameter int CS_GAP     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_dc,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       mosi,
  output logic       sclk,
  output logic       cs,
  output logic       dc,
  output logic       busy,
  output logic       byte_done
);

  localparam int PHASE_MAX = (DIV_HALF > CS_GAP) ? DIV_HALF : CS_GAP;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV_HALF - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(CS_GAP - 1);

  logic [2:0]             state;
  logic [PW-1:0]          phase;
  logic [2:0]             bit_cnt;
  logic [7:0]             tx_byte;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LCD_ENTRY_W-1:0] head;
  logic [CW-1:0]          fifo_count;
  logic                   phase_end;
  logic                   byte_end;

  lcd_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_entry({wr_dc, wr_data}),
    .pop     (pop),
    .rd_entry(head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign wr_ready  = !fifo_full;
  assign push      = wr_valid && wr_ready;
  assign phase_end = (phase == DIV_LAST);
  assign byte_end  = (state == ST_LOW) && phase_end && (bit_cnt == 3'd0);
  assign busy      = (fifo_count != '0) || (state != ST_IDLE);

  // A new byte is taken either from IDLE or straight at the end of the
  // previous byte, which is what keeps cs low across queued bytes.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty && ((state == ST_IDLE) || byte_end)) begin
      pop = 1'b1;
    end
  end

  // Serialiser FSM. bit_cnt names the bit currently on mosi; the next bit
  // is presented when sclk falls, so mosi and dc only move while sclk is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      phase     <= '0;
      bit_cnt   <= 3'd0;
      tx_byte   <= 8'h00;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      dc        <= DC_CMD;
      byte_done <= 1'b0;
    end else begin
      byte_done <= byte_end;
      if (pop) begin
        tx_byte <= head[7:0];
        dc      <= head[8];
        mosi    <= head[7];
        cs      <= 1'b0;
        sclk    <= 1'b0;
        bit_cnt <= 3'd7;
        phase   <= '0;
        state   <= ST_SETUP;
      end else begin
        case (state)
          ST_IDLE: begin
            phase <= '0;
          end
          ST_SETUP: begin
            if (phase_end) begin
              phase <= '0;
              sclk  <= 1'b1;
              state <= ST_HIGH;
            end else begin
              phase <= phase + 1'b1;
            end
          end
          ST_HIGH: begin
            if (phase_end) begin
              phase <= '0;
              sclk  <= 1'b0;
              state <= ST_LOW;
              if (bit_cnt != 3'd0) begin
                mosi <= tx_byte[bit_cnt - 3'd1];
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          ST_LOW: begin
            if (phase_end) begin
              phase <= '0;
              if (bit_cnt == 3'd0) begin
                cs    <= 1'b1;
                mosi  <= 1'b0;
                state <= ST_GAP;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
                sclk    <= 1'b1;
                state   <= ST_HIGH;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          ST_GAP: begin
            if (phase == GAP_LAST) begin
              phase <= '0;
              state <= ST_IDLE;
            end else begin
              phase <= phase + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            phase <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Self-checking bench for lcd_spi_tx. A timeline model (queue of accepted
// entries plus cycle position within the current byte) predicts every
// output each cycle; directed scenarios add literal checks on frame length,
// sclk edge counts, received bytes and handshake timing.
module tb_lcd_spi_tx;
  import lcd_pkg::*;

  localparam int DIV_HALF = 2;
  localparam int CS_GAP   = 2;
  localparam int DEPTH    = 4;
  localparam int BYTE_CYC = 17 * DIV_HALF;
  localparam int M_IDLE   = 0;
  localparam int M_ACT    = 1;
  localparam int M_GAP    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_dc = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready, mosi, sclk, cs, dc, busy, byte_done;

  lcd_spi_tx #(
    .DIV_HALF  (DIV_HALF),
    .CS_GAP    (CS_GAP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_dc    (wr_dc),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .mosi     (mosi),
    .sclk     (sclk),
    .cs       (cs),
    .dc       (dc),
    .busy     (busy),
    .byte_done(byte_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: queued entries stamped with their acceptance cycle, and
  // where on the frame timeline the link currently is.
  typedef struct {
    logic [8:0] e;
    int         t;
  } ent_t;
  ent_t       mq[$];
  int         cyc = 0;
  int         mode = M_IDLE;
  int         p = 0;
  int         g = 0;
  logic [8:0] cur = 9'h000;
  logic       m_done = 1'b0;

  // Monitor state: totals that scenarios snapshot and difference.
  int          rises = 0, dones = 0, cs_falls = 0, dc_rises = 0;
  int          run = 0, last_run = 0, hrun = 0, last_hrun = 0;
  logic [63:0] rx = 64'h0;
  logic        prev_sclk = 1'b0, prev_dc = 1'b0;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model step on each edge: entries are poppable two edges after they were
  // accepted, each byte lasts BYTE_CYC cycles, a frame is followed by CS_GAP
  // cycles of cs high and one idle cycle before the next frame starts.
  task automatic modelLoop();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mq.delete();
        mode   = M_IDLE;
        p      = 0;
        g      = 0;
        cur    = 9'h000;
        m_done = 1'b0;
      end else begin
        bit   accept;
        bit   can_pop;
        ent_t h;
        cyc++;
        accept  = wr_valid && (mq.size() != DEPTH);
        can_pop = (mq.size() != 0) && (mq[0].t <= cyc - 2);
        m_done  = 1'b0;
        case (mode)
          M_IDLE: begin
            if (can_pop) begin
              h = mq.pop_front();
              cur = h.e;
              mode = M_ACT;
              p = 0;
            end
          end
          M_ACT: begin
            p++;
            if (p == BYTE_CYC) begin
              m_done = 1'b1;
              if (can_pop) begin
                h = mq.pop_front();
                cur = h.e;
                p = 0;
              end else begin
                mode = M_GAP;
                g = 0;
              end
            end
          end
          default: begin
            g++;
            if (g == CS_GAP) mode = M_IDLE;
          end
        endcase
        if (accept) mq.push_back('{e: {wr_dc, wr_data}, t: cyc});
      end
    end
  endtask

  task automatic compareLoop();
    forever begin
      int s;
      int idx;
      @(negedge clk);
      s = p / DIV_HALF;
      idx = 7 - s / 2;
      if (idx < 0) idx = 0;
      checkOutput("cs", int'(cs), int'(mode != M_ACT));
      checkOutput("sclk", int'(sclk), int'((mode == M_ACT) && (s % 2 == 1)));
      checkOutput("mosi", int'(mosi), (mode == M_ACT) ? int'(cur[idx]) : 0);
      checkOutput("dc", int'(dc), int'(cur[8]));
      checkOutput("busy", int'(busy), int'((mq.size() != 0) || (mode != M_IDLE)));
      checkOutput("wr_ready", int'(wr_ready), int'(mq.size() != DEPTH));
      checkOutput("byte_done", int'(byte_done), int'(m_done));
    end
  endtask

  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      if (sclk && !prev_sclk) begin
        rises++;
        rx = {rx[62:0], mosi};
      end
      if (byte_done) dones++;
      if (!cs) begin
        if (run == 0) begin
          cs_falls++;
          if (hrun > 0) last_hrun = hrun;
        end
        run++;
        hrun = 0;
        if (dc && !prev_dc) dc_rises++;
      end else begin
        if (run > 0) last_run = run;
        run = 0;
        hrun++;
      end
      prev_sclk = sclk;
      prev_dc = dc;
    end
  endtask

  // Offer one entry and wait (bounded) until it is taken. Called just after
  // a rising edge; returns just after the accepting edge with wr_valid high.
  task automatic applyStimulus(input logic d, input logic [7:0] b, output int waited);
    bit ok;
    wr_dc = d;
    wr_data = b;
    wr_valid = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited < 1000) begin
      @(negedge clk);
      ok = wr_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!ok) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitIdle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) checkOutput("idle_timeout", 1, 0);
  endtask

  initial begin
    int          w;
    int          r0, d0, f0, dcr0;
    logic [47:0] exp48;
    logic [7:0]  fb [6];

    fork
      modelLoop();
      compareLoop();
      monitorLoop();
    join_none

    $display("[TB] lcd_spi_tx bench start");

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_cs", int'(cs), 1);
    checkOutput("rst_sclk", int'(sclk), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_ready", int'(wr_ready), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single byte: command 0x21.
    r0 = rises; d0 = dones; f0 = cs_falls; dcr0 = dc_rises;
    applyStimulus(DC_CMD, 8'h21, w);
    wr_valid = 1'b0;
    checkOutput("lat_cs_edge0", int'(cs), 1);
    @(posedge clk);
    #1;
    checkOutput("lat_cs_edge1", int'(cs), 1);
    @(posedge clk);
    #1;
    checkOutput("lat_cs_edge2", int'(cs), 0);
    waitIdle(200);
    checkOutput("single_rises", rises - r0, 8);
    checkOutput("single_byte", int'(rx[7:0]), 'h21);
    checkOutput("single_done", dones - d0, 1);
    checkOutput("single_frames", cs_falls - f0, 1);
    checkOutput("single_cs_len", last_run, 34);
    checkOutput("single_dc_rise", dc_rises - dcr0, 0);

    // Back-to-back: three bytes in one frame, dc rising only for the third.
    r0 = rises; d0 = dones; f0 = cs_falls; dcr0 = dc_rises;
    applyStimulus(DC_CMD, 8'h21, w);
    applyStimulus(DC_CMD, 8'hC0, w);
    applyStimulus(DC_DATA, 8'h12, w);
    wr_valid = 1'b0;
    waitIdle(400);
    checkOutput("b2b_rises", rises - r0, 24);
    checkOutput("b2b_bytes", int'(rx[23:0]), 'h21C012);
    checkOutput("b2b_done", dones - d0, 3);
    checkOutput("b2b_frames", cs_falls - f0, 1);
    checkOutput("b2b_cs_len", last_run, 102);
    checkOutput("b2b_dc_rise", dc_rises - dcr0, 1);

    // Full FIFO: six distinct bytes offered back to back.
    fb[0] = 8'hA1; fb[1] = 8'h5B; fb[2] = 8'h3C; fb[3] = 8'hE4; fb[4] = 8'h0F; fb[5] = 8'h96;
    r0 = rises; d0 = dones; f0 = cs_falls;
    for (int i = 0; i < 5; i++) applyStimulus(DC_DATA, fb[i], w);
    checkOutput("full_ready", int'(wr_ready), 0);
    applyStimulus(DC_DATA, fb[5], w);
    checkOutput("full_wait_cycles", w, 33);
    wr_valid = 1'b0;
    waitIdle(600);
    exp48 = '0;
    for (int i = 0; i < 6; i++) exp48 = {exp48[39:0], fb[i]};
    checkOutput("full_bytes_hi", int'(rx[47:24]), int'(exp48[47:24]));
    checkOutput("full_bytes_lo", int'(rx[23:0]), int'(exp48[23:0]));
    checkOutput("full_done", dones - d0, 6);
    checkOutput("full_frames", cs_falls - f0, 1);
    checkOutput("full_cs_len", last_run, 6 * 34);

    // Reset in the middle of 0xFF, after the third sclk rise.
    r0 = rises;
    applyStimulus(DC_CMD, 8'hFF, w);
    wr_valid = 1'b0;
    for (int i = 0; i < 200 && (rises - r0) < 3; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("midrst_reached", rises - r0, 3);
    reset = 1'b0;
    #1;
    checkOutput("midrst_cs", int'(cs), 1);
    checkOutput("midrst_sclk", int'(sclk), 0);
    checkOutput("midrst_mosi", int'(mosi), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_ready", int'(wr_ready), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    r0 = rises; f0 = cs_falls;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("postrst_rises", rises - r0, 0);
    checkOutput("postrst_frames", cs_falls - f0, 0);
    checkOutput("postrst_busy", int'(busy), 0);

    // Gap restart: second byte written while cs is held high after the first.
    r0 = rises; d0 = dones; f0 = cs_falls;
    applyStimulus(DC_DATA, 8'h5A, w);
    wr_valid = 1'b0;
    w = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (byte_done) begin
        w = 1;
        break;
      end
    end
    checkOutput("gap_done_seen", w, 1);
    wr_dc = DC_CMD;
    wr_data = 8'h3C;
    wr_valid = 1'b1;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    waitIdle(300);
    checkOutput("gap_high_cycles", last_hrun, CS_GAP + 1);
    checkOutput("gap_bytes", int'(rx[15:0]), 'h5A3C);
    checkOutput("gap_done", dones - d0, 2);
    checkOutput("gap_frames", cs_falls - f0, 2);
    checkOutput("gap_cs_len", last_run, 34);

    // Randomised traffic with random idle stretches.
    d0 = dones;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(logic'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), w);
      if ($urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        repeat ($urandom_range(1, 60)) @(posedge clk);
        #1;
      end
    end
    wr_valid = 1'b0;
    waitIdle(3000);
    checkOutput("rand_done", dones - d0, 40);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_spi_tx.md
Name: lcd_spi_tx

Overview:
Write-only SPI byte transmitter for the PCD8544 LCD link, sitting directly downstream of the LCD command/data sequencer.
- Accepts {dc, byte} pairs through a valid/ready handshake into a small FIFO.
- Serialises each byte MSB-first in SPI mode 0 and drives mosi/sclk/cs/dc to the panel.
- Holds cs low across back-to-back bytes so multi-byte command sequences stay in one frame.

Parameters:
DIV_HALF, 2, sclk half-period in clk cycles (legal range ≥1)
CS_GAP, 2, clk cycles cs is held high after a frame ends before a new frame may start (≥1)
FIFO_DEPTH, 4, entries of {dc, byte}; power of 2, ≥2

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-low
wr_data  in  8  byte to transmit
wr_dc  in  1  0 = command, 1 = display data; travels with wr_data
wr_valid  in  1  sequencer offers {wr_dc, wr_data}
wr_ready  out  1  FIFO can accept; a transfer happens when wr_valid & wr_ready at a rising edge
mosi  out  1  serial data to panel
sclk  out  1  SPI clock, idle low
cs  out  1  chip select, active-low
dc  out  1  D/C line to panel
busy  out  1  high while the FIFO is non-empty or the FSM is not IDLE
byte_done  out  1  one-cycle pulse after the last bit of each byte

Behaviour:
- Reset (async assert, sync release): FIFO emptied, FSM in IDLE, cs=1, sclk=0, mosi=0, dc=0, busy=0, byte_done=0, wr_ready=1. Asserting reset mid-byte aborts immediately; the partial byte and queued bytes are discarded.
- FIFO: registered count.
  - wr_ready = (count != FIFO_DEPTH).
  - If push and pop occur in the same cycle, count is unchanged.
  - When full, wr_ready=0, so a same-cycle pop does not admit a write.
- FSM states: IDLE, SETUP, HIGH, LOW, GAP. A phase counter counts DIV_HALF cycles per phase. A 3-bit bit counter runs 7→0.
  - IDLE: if FIFO is non-empty, pop into the shift register and dc register, drive cs=0 and mosi=bit7, go to SETUP. Latency: a byte written at edge T into an empty idle block shows cs low after edge T+2.
  - SETUP: sclk=0 for DIV_HALF cycles, then go to HIGH.
  - HIGH: sclk=1 for DIV_HALF cycles; the panel samples on the rising edge. Then go to LOW.
  - LOW: sclk=0 for DIV_HALF cycles.
    - At LOW entry, if bits remain, mosi is set to the next bit.
    - When LOW ends after bit 0, byte_done pulses for 1 cycle.
    - If the FIFO is non-empty at that moment, pop the next byte (cs stays 0, dc and mosi update) and go to SETUP.
    - Otherwise go to GAP.
  - GAP: cs=1, sclk=0, mosi=0 for CS_GAP cycles, then go to IDLE.
- dc and mosi change only while sclk=0. dc is stable for the whole byte, including bit 0, which is where the PCD8544 samples D/C.
- Timing per byte with cs low: 17*DIV_HALF cycles. Exactly 8 sclk rising edges per byte. No sclk toggling outside SETUP/HIGH/LOW.
- A write arriving during GAP is queued; the new frame starts from IDLE after the gap.

Decomposition:
- Shared package lcd_pkg holds:
  - DC_CMD=1'b0 and DC_DATA=1'b1
  - the FSM state encoding (3 bits: IDLE, SETUP, HIGH, LOW, GAP)
  - the entry width constant LCD_ENTRY_W=9 ({dc, byte})
- Sub-module lcd_tx_fifo: synchronous FIFO, DEPTH parameter, 9-bit entries, push/pop/full/empty/count, async active-low reset. lcd_spi_tx instantiates it once.

Test Plan:
- Single byte (DIV_HALF=2): write dc=0, data=0x21 into an idle block.
  - cs low after the 2nd edge and held for 34 cycles.
  - mosi sampled on 8 sclk rises = 0,0,1,0,0,0,0,1; dc=0 throughout.
  - byte_done pulses once; cs high for 2 cycles, then busy=0.
- Back-to-back: write {0,0x21}, {0,0xC0}, {1,0x12} on consecutive cycles.
  - cs stays low for one continuous 102-cycle frame with 24 sclk rises.
  - dc rises only at the start of byte 3; 3 byte_done pulses.
- Full FIFO: hold wr_valid high with 6 distinct bytes while the link is busy.
  - Five are accepted (one in the shifter plus 4 queued); wr_ready drops to 0.
  - wr_ready rises the cycle after the next pop.
  - All accepted bytes are emitted in order; the 6th is accepted only after space frees.
- Reset mid-byte: assert reset after the 3rd sclk rise of 0xFF.
  - In the same cycle: cs=1, sclk=0, mosi=0, busy=0.
  - After release, with no writes, no sclk activity for 100 cycles.
- Gap restart: write a byte during GAP.
  - cs stays high for the full CS_GAP cycles, then re-asserts 1 cycle after IDLE.
  - The byte is transmitted correctly.
